// File: rtl/tx_video_pkg.sv
// Shared types and default 1024x768 timing for the HDMI transmit raster.
// TX_TESTPATTERN_EN selects the colour-bar fill pixel via bar_color().
package tx_video_pkg;

  localparam int CNT_W = 12;

  localparam int DEF_H_ACTIVE  = 1024;
  localparam int DEF_H_FP      = 24;
  localparam int DEF_H_SYNC    = 136;
  localparam int DEF_H_BP      = 160;
  localparam int DEF_V_ACTIVE  = 768;
  localparam int DEF_V_FP      = 3;
  localparam int DEF_V_SYNC    = 6;
  localparam int DEF_V_BP      = 29;
  localparam int DEF_BAR_SHIFT = 7;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Bar colours, packed {B,G,R}
  localparam logic [23:0] BAR0 = 24'hFFFFFF;
  localparam logic [23:0] BAR1 = 24'h00FFFF;
  localparam logic [23:0] BAR2 = 24'hFFFF00;
  localparam logic [23:0] BAR3 = 24'h00FF00;
  localparam logic [23:0] BAR4 = 24'hFF00FF;
  localparam logic [23:0] BAR5 = 24'h0000FF;
  localparam logic [23:0] BAR6 = 24'hFF0000;
  localparam logic [23:0] BAR7 = 24'h000000;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR0;
      3'd1:    return BAR1;
      3'd2:    return BAR2;
      3'd3:    return BAR3;
      3'd4:    return BAR4;
      3'd5:    return BAR5;
      3'd6:    return BAR6;
      default: return BAR7;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters with wrap logic and sync/active decodes.
// Counters hold at zero whenever run is low.
module video_timing_counter
  import tx_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic [CNT_W-1:0] hc,
  output logic [CNT_W-1:0] vc,
  output logic             active,
  output logic             hsync_on,
  output logic             vsync_on,
  output logic             frame_last
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_total_check
    $error("video_timing_counter: raster totals exceed counter range");
  end

  logic h_last, v_last;

  assign h_last     = (int'(hc) == H_TOTAL - 1);
  assign v_last     = (int'(vc) == V_TOTAL - 1);
  assign frame_last = h_last && v_last;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last) begin
      hc <= '0;
      vc <= v_last ? '0 : vc + 1'b1;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // vc only moves on the hc wrap, so the vertical decode changes at hc=0
  assign active   = (int'(hc) < H_ACTIVE) && (int'(vc) < V_ACTIVE);
  assign hsync_on = (int'(hc) >= H_ACTIVE + H_FP) && (int'(hc) < H_ACTIVE + H_FP + H_SYNC);
  assign vsync_on = (int'(vc) >= V_ACTIVE + V_FP) && (int'(vc) < V_ACTIVE + V_FP + V_SYNC);

endmodule

// File: rtl/tx_video_timing_gen.sv
// HDMI transmit raster: run/drain FSM, pixel handshake, underrun fill, output registers.
// TX_TESTPATTERN_EN: underrun fill is an 8-bar colour pattern instead of black.
//
//  state | meaning
//  IDLE  | counters held at 0, outputs at reset values
//  RUN   | raster advancing, enable requested
//  DRAIN | enable dropped, finishing current frame
module tx_video_timing_gen
  import tx_video_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int BAR_SHIFT = DEF_BAR_SHIFT
) (
  input  logic        tx_pclk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_rd,
  output logic        frame_start,
  output logic [23:0] tx_rgb,
  output logic        tx_de,
  output logic        tx_hsync,
  output logic        tx_vsync,
  output logic        underrun,
  input  logic        underrun_clr
);

  if (BAR_SHIFT + 3 > CNT_W) begin : g_bar_check
    $error("tx_video_timing_gen: bar index exceeds counter width");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] hc, vc;
  logic             active, hsync_on, vsync_on, frame_last;
  logic             running;
  logic [23:0]      fill_pix;

  assign running = (state != IDLE);

  video_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_counter (
    .clk       (tx_pclk),
    .rst       (rst),
    .run       (running),
    .hc        (hc),
    .vc        (vc),
    .active    (active),
    .hsync_on  (hsync_on),
    .vsync_on  (vsync_on),
    .frame_last(frame_last)
  );

  always_ff @(posedge tx_pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Disabling never cuts a frame short: leave for IDLE only on the last pixel
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (enable) state_n = RUN;
      RUN:     if (!enable) state_n = frame_last ? IDLE : DRAIN;
      DRAIN: begin
        if (enable)          state_n = RUN;
        else if (frame_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pix_rd      = running && active;
  assign frame_start = running && (hc == '0) && (vc == '0);

`ifdef TX_TESTPATTERN_EN
  assign fill_pix = bar_color(hc[BAR_SHIFT+2:BAR_SHIFT]);
`else
  assign fill_pix = 24'h000000;
`endif

  always_ff @(posedge tx_pclk) begin
    if (rst) begin
      tx_de    <= 1'b0;
      tx_rgb   <= '0;
      tx_hsync <= ~HSYNC_POL;
      tx_vsync <= ~VSYNC_POL;
      underrun <= 1'b0;
    end else begin
      tx_de    <= pix_rd;
      tx_rgb   <= !pix_rd ? 24'h000000 : (pix_valid ? pix_data : fill_pix);
      tx_hsync <= (running && hsync_on) ? HSYNC_POL : ~HSYNC_POL;
      tx_vsync <= (running && vsync_on) ? VSYNC_POL : ~VSYNC_POL;
      // A new underrun in the clearing cycle keeps the flag set
      underrun <= (pix_rd && !pix_valid) || (underrun && !underrun_clr);
    end
  end

endmodule
